decode_pipe: RTL and testbench

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe_if.sv | 26 ++
 rtl/decode_pipe.sv | 164 ++++++++++++++++
 tb/tb_decode_pipe.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/decode_pipe_if.sv
// Handshake bundle for decode_pipe: instruction input side and decoded-entry output side.
interface decode_pipe_if #(
   parameter int CTRL_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       instr;
   logic [31:0]       in_pc;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_alucontrol;
   logic [31:0]       out_pc;
   logic [31:0]       out_instr;
   logic              out_ri;
   logic              out_sys;
   logic              out_brk;

   modport slave (
      input  in_valid, instr, in_pc, out_ready,
      output in_ready, out_valid, out_alucontrol, out_pc, out_instr, out_ri, out_sys, out_brk
   );
   modport master (
      output in_valid, instr, in_pc, out_ready,
      input  in_ready, out_valid, out_alucontrol, out_pc, out_instr, out_ri, out_sys, out_brk
   );
endinterface

// File: rtl/decode_pipe.sv
// MIPS instruction decoder with a registered output stage: a plain register (DEPTH=1)
// or a two-entry skid buffer (DEPTH=2) whose in_ready comes straight from a flop.
module decode_pipe #(
   parameter int CTRL_W = 8,
   parameter int DEPTH  = 2,
   parameter bit CP0_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   decode_pipe_if.slave bus
);
   localparam logic [7:0] EXE_NOP_OP  = 8'h00, EXE_SLL_OP   = 8'h7C, EXE_SRL_OP   = 8'h02;
   localparam logic [7:0] EXE_SRA_OP  = 8'h03, EXE_SLLV_OP  = 8'h04, EXE_SRLV_OP  = 8'h06;
   localparam logic [7:0] EXE_SRAV_OP = 8'h07, EXE_JR_OP    = 8'h08, EXE_JALR_OP  = 8'h09;
   localparam logic [7:0] EXE_MFHI_OP = 8'h10, EXE_MTHI_OP  = 8'h11, EXE_MFLO_OP  = 8'h12;
   localparam logic [7:0] EXE_MTLO_OP = 8'h13, EXE_MULT_OP  = 8'h18, EXE_MULTU_OP = 8'h19;
   localparam logic [7:0] EXE_DIV_OP  = 8'h1A, EXE_DIVU_OP  = 8'h1B, EXE_ADD_OP   = 8'h20;
   localparam logic [7:0] EXE_ADDU_OP = 8'h21, EXE_SUB_OP   = 8'h22, EXE_SUBU_OP  = 8'h23;
   localparam logic [7:0] EXE_AND_OP  = 8'h24, EXE_OR_OP    = 8'h25, EXE_XOR_OP   = 8'h26;
   localparam logic [7:0] EXE_NOR_OP  = 8'h27, EXE_SLT_OP   = 8'h2A, EXE_SLTU_OP  = 8'h2B;
   localparam logic [7:0] EXE_BLTZ_OP = 8'h40, EXE_BGEZ_OP  = 8'h41, EXE_BLTZAL_OP = 8'h4A;
   localparam logic [7:0] EXE_BGEZAL_OP = 8'h4B, EXE_J_OP   = 8'h4F, EXE_JAL_OP   = 8'h50;
   localparam logic [7:0] EXE_BEQ_OP  = 8'h51, EXE_BNE_OP   = 8'h52, EXE_BLEZ_OP  = 8'h53;
   localparam logic [7:0] EXE_BGTZ_OP = 8'h54, EXE_ADDI_OP  = 8'h55, EXE_ADDIU_OP = 8'h56;
   localparam logic [7:0] EXE_SLTI_OP = 8'h57, EXE_SLTIU_OP = 8'h58, EXE_ANDI_OP  = 8'h59;
   localparam logic [7:0] EXE_ORI_OP  = 8'h5A, EXE_XORI_OP  = 8'h5B, EXE_LUI_OP   = 8'h5C;
   localparam logic [7:0] EXE_MFC0_OP = 8'h5D, EXE_MTC0_OP  = 8'h60, EXE_ERET_OP  = 8'h6B;
   localparam logic [7:0] EXE_LB_OP   = 8'hE0, EXE_LH_OP    = 8'hE1, EXE_LW_OP    = 8'hE3;
   localparam logic [7:0] EXE_LBU_OP  = 8'hE4, EXE_LHU_OP   = 8'hE5, EXE_SB_OP    = 8'hE8;
   localparam logic [7:0] EXE_SH_OP   = 8'hE9, EXE_SW_OP    = 8'hEB;

   typedef struct packed {
      logic [CTRL_W-1:0] alu;
      logic [31:0]       pc;
      logic [31:0]       instr;
      logic              ri;
      logic              sys;
      logic              brk;
   } entry_t;

   logic [5:0] op, funct;
   logic [4:0] rs, rt;
   logic [7:0] dec_alu;
   logic       dec_ri, dec_sys, dec_brk;
   entry_t     dec_entry;

   assign op    = bus.instr[31:26];
   assign rs    = bus.instr[25:21];
   assign rt    = bus.instr[20:16];
   assign funct = bus.instr[5:0];

   always_comb begin
      dec_alu = EXE_NOP_OP;
      dec_ri  = 1'b0;
      dec_sys = 1'b0;
      dec_brk = 1'b0;
      case (op)
         6'h00: begin
            case (funct)
               6'h00: dec_alu = EXE_SLL_OP;   6'h02: dec_alu = EXE_SRL_OP;
               6'h03: dec_alu = EXE_SRA_OP;   6'h04: dec_alu = EXE_SLLV_OP;
               6'h06: dec_alu = EXE_SRLV_OP;  6'h07: dec_alu = EXE_SRAV_OP;
               6'h08: dec_alu = EXE_JR_OP;    6'h09: dec_alu = EXE_JALR_OP;
               6'h0C: dec_sys = 1'b1;         6'h0D: dec_brk = 1'b1;
               6'h10: dec_alu = EXE_MFHI_OP;  6'h11: dec_alu = EXE_MTHI_OP;
               6'h12: dec_alu = EXE_MFLO_OP;  6'h13: dec_alu = EXE_MTLO_OP;
               6'h18: dec_alu = EXE_MULT_OP;  6'h19: dec_alu = EXE_MULTU_OP;
               6'h1A: dec_alu = EXE_DIV_OP;   6'h1B: dec_alu = EXE_DIVU_OP;
               6'h20: dec_alu = EXE_ADD_OP;   6'h21: dec_alu = EXE_ADDU_OP;
               6'h22: dec_alu = EXE_SUB_OP;   6'h23: dec_alu = EXE_SUBU_OP;
               6'h24: dec_alu = EXE_AND_OP;   6'h25: dec_alu = EXE_OR_OP;
               6'h26: dec_alu = EXE_XOR_OP;   6'h27: dec_alu = EXE_NOR_OP;
               6'h2A: dec_alu = EXE_SLT_OP;   6'h2B: dec_alu = EXE_SLTU_OP;
               default: dec_ri = 1'b1;
            endcase
         end
         6'h01: begin
            case (rt)
               5'h00: dec_alu = EXE_BLTZ_OP;    5'h01: dec_alu = EXE_BGEZ_OP;
               5'h10: dec_alu = EXE_BLTZAL_OP;  5'h11: dec_alu = EXE_BGEZAL_OP;
               default: dec_ri = 1'b1;
            endcase
         end
         6'h02: dec_alu = EXE_J_OP;     6'h03: dec_alu = EXE_JAL_OP;
         6'h04: dec_alu = EXE_BEQ_OP;   6'h05: dec_alu = EXE_BNE_OP;
         6'h06: dec_alu = EXE_BLEZ_OP;  6'h07: dec_alu = EXE_BGTZ_OP;
         6'h08: dec_alu = EXE_ADDI_OP;  6'h09: dec_alu = EXE_ADDIU_OP;
         6'h0A: dec_alu = EXE_SLTI_OP;  6'h0B: dec_alu = EXE_SLTIU_OP;
         6'h0C: dec_alu = EXE_ANDI_OP;  6'h0D: dec_alu = EXE_ORI_OP;
         6'h0E: dec_alu = EXE_XORI_OP;  6'h0F: dec_alu = EXE_LUI_OP;
         6'h10: begin
            if (CP0_EN && rs == 5'h00)                   dec_alu = EXE_MFC0_OP;
            else if (CP0_EN && rs == 5'h04)              dec_alu = EXE_MTC0_OP;
            else if (CP0_EN && bus.instr == 32'h42000018) dec_alu = EXE_ERET_OP;
            else                                         dec_ri  = 1'b1;
         end
         6'h20: dec_alu = EXE_LB_OP;    6'h21: dec_alu = EXE_LH_OP;
         6'h23: dec_alu = EXE_LW_OP;    6'h24: dec_alu = EXE_LBU_OP;
         6'h25: dec_alu = EXE_LHU_OP;   6'h28: dec_alu = EXE_SB_OP;
         6'h29: dec_alu = EXE_SH_OP;    6'h2B: dec_alu = EXE_SW_OP;
         default: dec_ri = 1'b1;
      endcase
   end

   assign dec_entry = {CTRL_W'(dec_alu), bus.in_pc, bus.instr, dec_ri, dec_sys, dec_brk};

   entry_t out_q, out_d, skid_q, skid_d;
   logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
   logic   accept, drain;

   // Skid occupancy is exactly "buffer full", so it doubles as the registered in_ready.
   assign bus.in_ready = (DEPTH == 1) ? (!out_valid_q || bus.out_ready) : !skid_valid_q;
   assign accept       = bus.in_valid && bus.in_ready;
   assign drain        = out_valid_q && bus.out_ready;

   always_comb begin
      out_d        = out_q;
      skid_d       = skid_q;
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || drain) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_d       = dec_entry;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d       = dec_entry;
         skid_valid_d = 1'b1;
      end
      if (DEPTH == 1) skid_valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign bus.out_valid      = out_valid_q;
   assign bus.out_alucontrol = out_q.alu;
   assign bus.out_pc         = out_q.pc;
   assign bus.out_instr      = out_q.instr;
   assign bus.out_ri         = out_q.ri;
   assign bus.out_sys        = out_q.sys;
   assign bus.out_brk        = out_q.brk;
endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed cases then random valid/ready/flush/reset traffic,
// compared against a table-driven decoder and an in-order queue of expected entries.
module tb_decode_pipe;
   localparam int CTRL_W = 8;

   logic clk = 1'b0;
   logic rst, flush;
   always #5 clk = ~clk;

   decode_pipe_if #(.CTRL_W(CTRL_W)) bus_a ();
   decode_pipe_if #(.CTRL_W(CTRL_W)) bus_b ();

   decode_pipe #(.CTRL_W(CTRL_W), .DEPTH(2), .CP0_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus_a));
   decode_pipe #(.CTRL_W(CTRL_W), .DEPTH(1), .CP0_EN(1'b0)) dut_b (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus_b));

   typedef struct {
      logic [7:0]  alu;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        ri;
      logic        sys;
      logic        brk;
   } exp_t;

   logic [7:0] rtab [int];
   logic [7:0] itab [int];
   logic [7:0] gtab [int];
   exp_t       q [$];
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc, input bit cp0);
      exp_t e;
      int op = int'(ins[31:26]);
      int rs = int'(ins[25:21]);
      int rt = int'(ins[20:16]);
      int fn = int'(ins[5:0]);
      e.alu = 8'h00; e.pc = pc; e.instr = ins; e.ri = 1'b0; e.sys = 1'b0; e.brk = 1'b0;
      if (op == 0 && fn == 12)                   e.sys = 1'b1;
      else if (op == 0 && fn == 13)              e.brk = 1'b1;
      else if (op == 0 && rtab.exists(fn))       e.alu = rtab[fn];
      else if (op == 1 && gtab.exists(rt))       e.alu = gtab[rt];
      else if (op > 1 && itab.exists(op))        e.alu = itab[op];
      else if (cp0 && ins == 32'h42000018)       e.alu = 8'h6B;
      else if (cp0 && op == 16 && rs == 0)       e.alu = 8'h5D;
      else if (cp0 && op == 16 && rs == 4)       e.alu = 8'h60;
      else                                       e.ri  = 1'b1;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w = $urandom;
      case ($urandom_range(0, 9))
         0, 1, 2: w[31:26] = 6'h00;
         3:       w[31:26] = 6'h01;
         4:       begin w[31:26] = 6'h10; if ($urandom_range(0, 1) == 1) w[25:21] = 5'h04; else w[25:21] = 5'h00; end
         5:       w = 32'h42000018;
         default: ;
      endcase
      return w;
   endfunction

   task automatic check_model();
      chk("in_ready", {79'd0, bus_a.in_ready}, {79'd0, q.size() < 2});
      chk("out_valid", {79'd0, bus_a.out_valid}, {79'd0, q.size() > 0});
      if (q.size() > 0)
         chk("entry", {5'd0, bus_a.out_alucontrol, bus_a.out_pc, bus_a.out_instr, bus_a.out_ri, bus_a.out_sys, bus_a.out_brk},
             {5'd0, q[0].alu, q[0].pc, q[0].instr, q[0].ri, q[0].sys, q[0].brk});
   endtask

   // One clock: drive at the falling edge, update the model, compare at the next falling edge.
   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
      bit can_take = (q.size() < 2);
      bit has_out  = (q.size() > 0);
      bus_a.in_valid  = v;
      bus_a.instr     = ins;
      bus_a.in_pc     = pc;
      bus_a.out_ready = rdy;
      flush           = fl;
      if (fl) q.delete();
      else begin
         if (has_out && rdy) void'(q.pop_front());
         if (v && can_take) q.push_back(ref_decode(ins, pc, 1'b1));
      end
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      flush = 1'b0;
      bus_a.in_valid = 1'b1;
      bus_a.instr = rand_instr();
      bus_a.in_pc = $urandom;
      bus_a.out_ready = 1'b0;
      q.delete();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus_a.in_valid = 1'b0;
      check_model();
   endtask

   initial begin
      rtab[0] = 8'h7C;  rtab[2] = 8'h02;  rtab[3] = 8'h03;  rtab[4] = 8'h04;  rtab[6] = 8'h06;
      rtab[7] = 8'h07;  rtab[8] = 8'h08;  rtab[9] = 8'h09;  rtab[16] = 8'h10; rtab[17] = 8'h11;
      rtab[18] = 8'h12; rtab[19] = 8'h13; rtab[24] = 8'h18; rtab[25] = 8'h19; rtab[26] = 8'h1A;
      rtab[27] = 8'h1B; rtab[32] = 8'h20; rtab[33] = 8'h21; rtab[34] = 8'h22; rtab[35] = 8'h23;
      rtab[36] = 8'h24; rtab[37] = 8'h25; rtab[38] = 8'h26; rtab[39] = 8'h27; rtab[42] = 8'h2A;
      rtab[43] = 8'h2B;
      gtab[0] = 8'h40;  gtab[1] = 8'h41;  gtab[16] = 8'h4A; gtab[17] = 8'h4B;
      itab[2] = 8'h4F;  itab[3] = 8'h50;  itab[4] = 8'h51;  itab[5] = 8'h52;  itab[6] = 8'h53;
      itab[7] = 8'h54;  itab[8] = 8'h55;  itab[9] = 8'h56;  itab[10] = 8'h57; itab[11] = 8'h58;
      itab[12] = 8'h59; itab[13] = 8'h5A; itab[14] = 8'h5B; itab[15] = 8'h5C; itab[32] = 8'hE0;
      itab[33] = 8'hE1; itab[35] = 8'hE3; itab[36] = 8'hE4; itab[37] = 8'hE5; itab[40] = 8'hE8;
      itab[41] = 8'hE9; itab[43] = 8'hEB;

      bus_b.in_valid = 1'b0; bus_b.instr = '0; bus_b.in_pc = '0; bus_b.out_ready = 1'b1;
      @(negedge clk);
      do_reset();
      chk("reset_alu", {72'd0, bus_a.out_alucontrol}, 80'd0);
      chk("reset_pc_instr", {16'd0, bus_a.out_pc, bus_a.out_instr}, 80'd0);
      chk("reset_flags", {77'd0, bus_a.out_ri, bus_a.out_sys, bus_a.out_brk}, 80'd0);

      // and $2,$4,$5
      step(1'b1, 32'h00851024, 32'h0000_0100, 1'b1, 1'b0);
      chk("and_valid", {79'd0, bus_a.out_valid}, 80'd1);
      chk("and_alu", {72'd0, bus_a.out_alucontrol}, 80'h24);
      chk("and_ri", {79'd0, bus_a.out_ri}, 80'd0);
      step(1'b1, 32'hFC000000, 32'h0000_0104, 1'b1, 1'b0);
      chk("resv_ri_alu", {71'd0, bus_a.out_ri, bus_a.out_alucontrol}, {71'd0, 1'b1, 8'h00});
      step(1'b1, 32'h0000000C, 32'h0000_0108, 1'b1, 1'b0);
      chk("syscall", {76'd0, bus_a.out_ri, bus_a.out_sys, bus_a.out_brk, bus_a.out_valid}, 80'b0101);
      step(1'b1, 32'h00000000, 32'h0000_010C, 1'b1, 1'b0);
      chk("nop_is_sll", {71'd0, bus_a.out_ri, bus_a.out_alucontrol}, {71'd0, 1'b0, 8'h7C});

      // mtc0 on both decoders: the second one has CP0 decode disabled
      bus_b.in_valid = 1'b1; bus_b.instr = 32'h40806000; bus_b.in_pc = 32'h0000_0200;
      step(1'b1, 32'h40806000, 32'h0000_0110, 1'b1, 1'b0);
      chk("mtc0_en", {72'd0, bus_a.out_alucontrol}, 80'h60);
      chk("mtc0_dis", {70'd0, bus_b.out_valid, bus_b.out_ri, bus_b.out_alucontrol}, {70'd0, 2'b11, 8'h00});
      bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0;
      #1 chk("d1_ready_stall", {79'd0, bus_b.in_ready}, 80'd0);
      bus_b.out_ready = 1'b1;
      #1 chk("d1_ready_pass", {79'd0, bus_b.in_ready}, 80'd1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // three back-to-back with the consumer stalled
      step(1'b1, 32'h00A41020, 32'h0000_0300, 1'b0, 1'b0);
      step(1'b1, 32'h8C820004, 32'h0000_0304, 1'b0, 1'b0);
      chk("full_ready", {79'd0, bus_a.in_ready}, 80'd0);
      step(1'b1, 32'h34420001, 32'h0000_0308, 1'b0, 1'b0);
      chk("full_hold", {48'd0, bus_a.out_instr}, {48'd0, 32'h00A41020});
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("drain2", {16'd0, bus_a.out_pc, bus_a.out_instr}, {16'd0, 32'h0000_0304, 32'h8C820004});
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("drained", {79'd0, bus_a.out_valid}, 80'd0);

      // flush with two buffered and a new input on the same cycle
      step(1'b1, 32'h00000020, 32'h0000_0400, 1'b0, 1'b0);
      step(1'b1, 32'h00000021, 32'h0000_0404, 1'b0, 1'b0);
      step(1'b1, 32'h00000022, 32'h0000_0408, 1'b0, 1'b1);
      chk("flush_valid", {79'd0, bus_a.out_valid}, 80'd0);
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      // flush while in_ready is high: the presented input must still be dropped
      step(1'b1, 32'h00000023, 32'h0000_0500, 1'b0, 1'b0);
      step(1'b1, 32'h00000024, 32'h0000_0504, 1'b1, 1'b1);
      chk("flush_drop", {79'd0, bus_a.out_valid}, 80'd0);

      for (int n = 0; n < 3000; n++) begin
         if (n % 700 == 350) do_reset();
         else step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                   $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
